// File: rtl/note_pkg.sv
// Shared note encoding, octave-5 reference frequencies and half-period helper
// for the piano tone datapath.
package note_pkg;

  typedef enum logic [3:0] {
    NOTE_C, NOTE_CS, NOTE_D, NOTE_DS, NOTE_E, NOTE_F,
    NOTE_FS, NOTE_G, NOTE_GS, NOTE_A, NOTE_AS, NOTE_B, NOTE_REST
  } note_e;

  typedef struct packed {
    logic [3:0] note;
    logic [2:0] oct;
    logic       gate;
  } shadow_t;

  // Octave-5 frequencies in mHz, C5 .. B5
  localparam longint unsigned F_MHZ [12] = '{
    64'd523251, 64'd554365, 64'd587330, 64'd622254, 64'd659255, 64'd698456,
    64'd739989, 64'd783991, 64'd830609, 64'd880000, 64'd932328, 64'd987767
  };

  function automatic longint unsigned half_period(
    input longint unsigned clk_hz,
    input int unsigned     note,
    input int unsigned     oct,
    input int unsigned     ref_oct = 5
  );
    longint unsigned h;
    if (note >= 12) return 64'd0;
    h = (clk_hz * 64'd1000) / (64'd2 * F_MHZ[note[3:0]]);
    if (oct > ref_oct) h = h >> (oct - ref_oct);
    else               h = h << (ref_oct - oct);
    return h;
  endfunction

endpackage

// File: rtl/tone_channel.sv
// One square-wave channel: shadow register, phase counter and tone state.
// Pitch/gate changes are sampled at the falling edge and applied after the low phase.
module tone_channel
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned REF_OCT = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [3:0] wr_note,
  input  logic [2:0] wr_oct,
  input  logic       wr_gate,
  output logic       tone,
  output logic       active
);

  if (half_period(CLK_HZ, 0, 0, REF_OCT) >= (64'd1 << CNT_W)) begin : g_cnt_w_check
    $error("tone_channel: CNT_W too small for the C0 half-period");
  end

  function automatic logic [15:0][CNT_W-1:0] build_tab();
    logic [15:0][CNT_W-1:0] t;
    t = '0;
    for (int unsigned n = 0; n < 12; n++)
      t[n] = CNT_W'(half_period(CLK_HZ, n, REF_OCT, REF_OCT));
    return t;
  endfunction

  localparam logic [15:0][CNT_W-1:0] HALF_TAB = build_tab();

  // Bit 1 = active, bit 0 = tone, so both outputs come straight from flops
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOW  = 2'b10,
    ST_HIGH = 2'b11
  } state_e;

  state_e           state, state_n;
  shadow_t          shadow;
  logic [CNT_W-1:0] cnt, cnt_n, tc, tc_n, pend_tc, pend_tc_n;
  logic [CNT_W-1:0] base, half, new_tc;
  logic             pend_ok, pend_ok_n, valid;

  always_comb begin
    valid = shadow.gate && (shadow.note < 4'(NOTE_REST));
    base  = HALF_TAB[shadow.note];
    if (shadow.oct > 3'(REF_OCT)) half = base >> (shadow.oct - 3'(REF_OCT));
    else                          half = base << (3'(REF_OCT) - shadow.oct);
    new_tc = (half == '0) ? '0 : half - CNT_W'(1);
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_W'(1);
    tc_n      = tc;
    pend_tc_n = pend_tc;
    pend_ok_n = pend_ok;
    unique case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (valid) begin
          state_n = ST_HIGH;
          tc_n    = new_tc;
        end
      end
      ST_HIGH: begin
        if (cnt == tc) begin
          cnt_n     = '0;
          state_n   = ST_LOW;
          pend_ok_n = valid;
          pend_tc_n = new_tc;
        end
      end
      ST_LOW: begin
        if (cnt == tc) begin
          cnt_n = '0;
          if (pend_ok) begin
            state_n = ST_HIGH;
            tc_n    = pend_tc;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      shadow  <= '0;
      cnt     <= '0;
      tc      <= '0;
      pend_tc <= '0;
      pend_ok <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      tc      <= tc_n;
      pend_tc <= pend_tc_n;
      pend_ok <= pend_ok_n;
      if (wr) shadow <= '{note: wr_note, oct: wr_oct, gate: wr_gate};
    end
  end

  assign tone   = state[0];
  assign active = state[1];

endmodule

// File: rtl/note_tone_bank.sv
// Polyphonic square-wave tone bank: N_CH tone_channel instances, write decode
// and a registered popcount of the tone outputs.
module note_tone_bank
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned REF_OCT = 5,
  localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int unsigned MIX_W  = $clog2(N_CH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [3:0]       wr_note,
  input  logic [2:0]       wr_oct,
  input  logic             wr_gate,
  output logic [N_CH-1:0]  tone_o,
  output logic [N_CH-1:0]  active_o,
  output logic [MIX_W-1:0] mix_o
);

  if (N_CH < 1 || N_CH > 16) begin : g_n_ch_check
    $error("note_tone_bank: N_CH must be 1..16");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    tone_channel #(
      .CLK_HZ  (CLK_HZ),
      .CNT_W   (CNT_W),
      .REF_OCT (REF_OCT)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr_en && (32'(wr_ch) == i)),
      .wr_note (wr_note),
      .wr_oct  (wr_oct),
      .wr_gate (wr_gate),
      .tone    (tone_o[i]),
      .active  (active_o[i])
    );
  end

  logic [MIX_W-1:0] pop;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < N_CH; i++) pop = pop + MIX_W'(tone_o[i]);
  end

  always_ff @(posedge clk) begin
    if (!reset) mix_o <= '0;
    else        mix_o <= pop;
  end

endmodule
